// File: rtl/events_to_apb_mc.sv
// Multi-channel event bridge: saturating per-channel event counters, each pending
// count reported as one APB write to ADDR_BASE + channel*ADDR_STRIDE.
module events_to_apb_mc #(
    parameter int          NUM_EVENTS  = 4,
    parameter int          CNT_W       = 16,
    parameter logic [31:0] ADDR_BASE   = 32'hE000_0000,
    parameter logic [31:0] ADDR_STRIDE = 32'h0001_0000,
    parameter int          ARB_MODE    = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_EVENTS-1:0] event_i,
    output logic                  apb_psel_o,
    output logic                  apb_penable_o,
    output logic [31:0]           apb_paddr_o,
    output logic                  apb_pwrite_o,
    output logic [31:0]           apb_pwdata_o,
    input  logic                  apb_pready_i,
    input  logic                  apb_pslverr_i,
    output logic [NUM_EVENTS-1:0] overflow_o,
    output logic                  busy_o
);
    localparam int IDX_W = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    state_t state_q, state_d;

    logic [NUM_EVENTS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_EVENTS-1:0]            ovf_q, ovf_d;
    logic [CNT_W-1:0]                 snap_q, snap_d;
    logic                             snap_ovf_q, snap_ovf_d;
    logic [IDX_W-1:0]                 gnt_q, gnt_d, ptr_q, ptr_d, ptr_inc;
    logic                             psel_q, psel_d, penable_q, penable_d;
    logic [31:0]                      paddr_q, paddr_d, pwdata_q, pwdata_d;

    logic [NUM_EVENTS-1:0]            pending, rot, rot_low, gnt_oh;
    logic [IDX_W-1:0][NUM_EVENTS-1:0] idx_mask;
    logic [CNT_W-1:0][NUM_EVENTS-1:0] cnt_cols;
    logic [IDX_W-1:0]                 off, grant;
    logic [IDX_W:0]                   grant_sum;
    logic [CNT_W-1:0]                 sel_cnt;
    logic                             sel_ovf, arb_valid, grab, done, retry;
    logic [31:0]                      grant_addr, grant_wdata;

    assign arb_valid = |pending;
    assign grab      = (state_q == IDLE) && arb_valid;
    assign done      = (state_q == ACCESS) && apb_pready_i;
    assign retry     = done && apb_pslverr_i;

    // Round robin rotates the request vector so the search starts at ptr, then
    // isolates the lowest set bit and converts the offset back to a channel index.
    assign rot       = (ARB_MODE == 1) ? NUM_EVENTS'({pending, pending} >> ptr_q) : pending;
    assign rot_low   = rot & (-rot);
    assign grant_sum = {1'b0, ptr_q} + {1'b0, off};
    assign grant     = (ARB_MODE != 1) ? off :
                       (grant_sum >= (IDX_W+1)'(NUM_EVENTS)) ?
                           IDX_W'(grant_sum - (IDX_W+1)'(NUM_EVENTS)) : IDX_W'(grant_sum);
    assign sel_ovf   = |(gnt_oh & ovf_q);
    assign ptr_inc   = (gnt_q == IDX_W'(NUM_EVENTS - 1)) ? '0 : gnt_q + IDX_W'(1);

    genvar gi, gb, gc;
    generate
        for (gi = 0; gi < NUM_EVENTS; gi++) begin : g_ch
            logic [CNT_W:0] inc_sum, err_sum;
            logic           grab_me, retry_me;

            assign pending[gi] = |cnt_q[gi];
            assign gnt_oh[gi]  = (grant == IDX_W'(gi));
            assign grab_me     = grab && gnt_oh[gi];
            assign retry_me    = retry && (gnt_q == IDX_W'(gi));
            assign inc_sum     = {1'b0, cnt_q[gi]} + (CNT_W+1)'(event_i[gi]);
            assign err_sum     = {1'b0, cnt_q[gi]} + {1'b0, snap_q} + (CNT_W+1)'(event_i[gi]);

            // A failed write folds the snapshot back so nothing is lost.
            assign cnt_d[gi] = grab_me  ? CNT_W'(event_i[gi]) :
                               retry_me ? (err_sum[CNT_W] ? CNT_MAX : err_sum[CNT_W-1:0]) :
                                          (inc_sum[CNT_W] ? CNT_MAX : inc_sum[CNT_W-1:0]);
            assign ovf_d[gi] = grab_me  ? 1'b0 :
                               retry_me ? (ovf_q[gi] | snap_ovf_q | err_sum[CNT_W]) :
                                          (ovf_q[gi] | inc_sum[CNT_W]);

            for (gb = 0; gb < IDX_W; gb++) begin : g_mask
                assign idx_mask[gb][gi] = ((gi >> gb) % 2) == 1;
            end
            for (gc = 0; gc < CNT_W; gc++) begin : g_col
                assign cnt_cols[gc][gi] = cnt_q[gi][gc];
            end
        end
        for (gb = 0; gb < IDX_W; gb++) begin : g_off
            assign off[gb] = |(rot_low & idx_mask[gb]);
        end
        for (gc = 0; gc < CNT_W; gc++) begin : g_sel
            assign sel_cnt[gc] = |(gnt_oh & cnt_cols[gc]);
        end
    endgenerate

    assign grant_addr = ADDR_BASE + ADDR_STRIDE * 32'(grant);

    always_comb begin
        grant_wdata              = '0;
        grant_wdata[31]          = sel_ovf;
        grant_wdata[CNT_W-1:0]   = sel_cnt;
    end

    assign snap_d     = grab ? sel_cnt : snap_q;
    assign snap_ovf_d = grab ? sel_ovf : snap_ovf_q;
    assign gnt_d      = grab ? grant : gnt_q;
    assign ptr_d      = done ? ptr_inc : ptr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            ovf_q      <= '0;
            snap_q     <= '0;
            snap_ovf_q <= 1'b0;
            gnt_q      <= '0;
            ptr_q      <= '0;
        end else begin
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            snap_q     <= snap_d;
            snap_ovf_q <= snap_ovf_d;
            gnt_q      <= gnt_d;
            ptr_q      <= ptr_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_valid) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (apb_pready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        psel_d    = (state_d != IDLE);
        penable_d = (state_d == ACCESS);
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        if (grab) begin
            paddr_d  = grant_addr;
            pwdata_d = grant_wdata;
        end else if (state_d == IDLE) begin
            paddr_d  = '0;
            pwdata_d = '0;
        end
    end

    assign apb_psel_o    = psel_q;
    assign apb_penable_o = penable_q;
    assign apb_paddr_o   = paddr_q;
    assign apb_pwrite_o  = 1'b1;
    assign apb_pwdata_o  = pwdata_q;
    assign overflow_o    = ovf_q;
    assign busy_o        = (state_q != IDLE);
endmodule

// File: tb/tb_events_to_apb_mc.sv
// Directed bench: three bridge instances (fixed priority, round robin, 4-bit counters)
// driven by one linear stimulus sequence with hand-computed expectations.
module tb_events_to_apb_mc;
    logic clk, rst_n;
    logic [3:0]  ev_a, ev_b, ev_c;
    logic        pready_a, pready_b, pready_c;
    logic        pslverr_a, pslverr_b, pslverr_c;
    logic        psel_a, psel_b, psel_c, pen_a, pen_b, pen_c;
    logic        pwrite_a, pwrite_b, pwrite_c, busy_a, busy_b, busy_c;
    logic [31:0] paddr_a, paddr_b, paddr_c, pwdata_a, pwdata_b, pwdata_c;
    logic [3:0]  ovf_a, ovf_b, ovf_c;
    int n_tests = 0;
    int n_fail  = 0;

    events_to_apb_mc #(.ARB_MODE(0)) dut_a (
        .clk(clk), .reset(rst_n), .event_i(ev_a),
        .apb_psel_o(psel_a), .apb_penable_o(pen_a), .apb_paddr_o(paddr_a),
        .apb_pwrite_o(pwrite_a), .apb_pwdata_o(pwdata_a),
        .apb_pready_i(pready_a), .apb_pslverr_i(pslverr_a),
        .overflow_o(ovf_a), .busy_o(busy_a));

    events_to_apb_mc #(.ARB_MODE(1)) dut_b (
        .clk(clk), .reset(rst_n), .event_i(ev_b),
        .apb_psel_o(psel_b), .apb_penable_o(pen_b), .apb_paddr_o(paddr_b),
        .apb_pwrite_o(pwrite_b), .apb_pwdata_o(pwdata_b),
        .apb_pready_i(pready_b), .apb_pslverr_i(pslverr_b),
        .overflow_o(ovf_b), .busy_o(busy_b));

    events_to_apb_mc #(.CNT_W(4)) dut_c (
        .clk(clk), .reset(rst_n), .event_i(ev_c),
        .apb_psel_o(psel_c), .apb_penable_o(pen_c), .apb_paddr_o(paddr_c),
        .apb_pwrite_o(pwrite_c), .apb_pwdata_o(pwdata_c),
        .apb_pready_i(pready_c), .apb_pslverr_i(pslverr_c),
        .overflow_o(ovf_c), .busy_o(busy_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("[TB] check %s observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        int n;
        logic [31:0] rr_exp [5];
        rr_exp[0] = 32'hE000_0000; rr_exp[1] = 32'hE001_0000; rr_exp[2] = 32'hE002_0000;
        rr_exp[3] = 32'hE003_0000; rr_exp[4] = 32'hE000_0000;

        rst_n = 1'b0;
        ev_a = '0; ev_b = '0; ev_c = '0;
        pready_a = 1'b1; pready_b = 1'b1; pready_c = 1'b1;
        pslverr_a = 1'b0; pslverr_b = 1'b0; pslverr_c = 1'b0;
        step(); step();

        // Reset state
        check("rst_psel", {31'b0, psel_a}, 32'd0);
        check("rst_penable", {31'b0, pen_a}, 32'd0);
        check("rst_paddr", paddr_a, 32'd0);
        check("rst_pwdata", pwdata_a, 32'd0);
        check("rst_pwrite", {31'b0, pwrite_a}, 32'd1);
        check("rst_busy", {31'b0, busy_a}, 32'd0);
        check("rst_ovf", {28'b0, ovf_a}, 32'd0);
        rst_n = 1'b1;
        step();

        // Single pulse on ch2, pready tied high
        ev_a = 4'b0100;
        step();
        ev_a = 4'b0000;
        check("t1_psel_n", {31'b0, psel_a}, 32'd0);
        step();
        check("t1_psel_n1", {31'b0, psel_a}, 32'd1);
        check("t1_pen_n1", {31'b0, pen_a}, 32'd0);
        check("t1_paddr", paddr_a, 32'hE002_0000);
        check("t1_pwdata", pwdata_a, 32'd1);
        check("t1_busy", {31'b0, busy_a}, 32'd1);
        step();
        check("t1_psel_n2", {31'b0, psel_a}, 32'd1);
        check("t1_pen_n2", {31'b0, pen_a}, 32'd1);
        step();
        check("t1_psel_end", {31'b0, psel_a}, 32'd0);
        check("t1_pen_end", {31'b0, pen_a}, 32'd0);
        check("t1_paddr_idle", paddr_a, 32'd0);
        check("t1_pwdata_idle", pwdata_a, 32'd0);
        step();
        check("t1_no_more", {31'b0, psel_a}, 32'd0);

        // ch1 transfer stalled while ch0 collects 5 pulses
        pready_a = 1'b0;
        ev_a = 4'b0010;
        step();
        ev_a = 4'b0000;
        step();
        check("t2_ch1_paddr", paddr_a, 32'hE001_0000);
        check("t2_ch1_pwdata", pwdata_a, 32'd1);
        for (int i = 0; i < 5; i++) begin
            ev_a = 4'b0001;
            step();
            check("t2_stall_pen", {31'b0, pen_a}, 32'd1);
            check("t2_stall_paddr", paddr_a, 32'hE001_0000);
            check("t2_stall_pwdata", pwdata_a, 32'd1);
        end
        ev_a = 4'b0000;
        pready_a = 1'b1;
        step();
        check("t2_gap_psel", {31'b0, psel_a}, 32'd0);
        step();
        check("t2_ch0_paddr", paddr_a, 32'hE000_0000);
        check("t2_ch0_pwdata", pwdata_a, 32'd5);
        step(); step();

        // Count 3 on ch1, slave error with one coincident event -> retry reports 4
        pready_a = 1'b0;
        ev_a = 4'b0001;
        step();
        ev_a = 4'b0010;
        step(); step(); step();
        ev_a = 4'b0000;
        pready_a = 1'b1;
        step();
        step();
        check("t5_paddr", paddr_a, 32'hE001_0000);
        check("t5_pwdata", pwdata_a, 32'd3);
        step();
        ev_a = 4'b0010;
        pslverr_a = 1'b1;
        step();
        ev_a = 4'b0000;
        pslverr_a = 1'b0;
        check("t5_err_idle", {31'b0, psel_a}, 32'd0);
        step();
        check("t5_retry_paddr", paddr_a, 32'hE001_0000);
        check("t5_retry_pwdata", pwdata_a, 32'd4);
        check("t5_ovf", {28'b0, ovf_a}, 32'd0);
        step(); step();

        // CNT_W=4: 20 pulses on ch3 while a ch0 transfer is stalled
        pready_c = 1'b0;
        ev_c = 4'b0001;
        step();
        ev_c = 4'b1000;
        step();
        for (int i = 0; i < 19; i++) step();
        ev_c = 4'b0000;
        check("t4_ovf_set", {28'b0, ovf_c}, 32'h8);
        pready_c = 1'b1;
        step();
        check("t4_ovf_hold", {28'b0, ovf_c}, 32'h8);
        step();
        check("t4_paddr", paddr_c, 32'hE003_0000);
        check("t4_pwdata", pwdata_c, 32'h8000_000F);
        check("t4_ovf_clr", {28'b0, ovf_c}, 32'h0);
        step(); step();

        // All channels pending: round robin rotates, fixed priority starves
        ev_a = 4'b1111;
        ev_b = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (!(psel_b && !pen_b) && n < 20) begin
                step();
                n++;
            end
            check("t3_wait", {31'b0, n < 20}, 32'd1);
            check("t3_rr_paddr", paddr_b, rr_exp[k]);
            check("t3_fp_paddr", paddr_a, 32'hE000_0000);
            if (k < 4) step();
        end

        // Reset asserted mid-ACCESS
        ev_a = 4'b0000;
        ev_b = 4'b0000;
        pready_a = 1'b0;
        step();
        check("t6_pen_before", {31'b0, pen_a}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_psel_drop", {31'b0, psel_a}, 32'd0);
        check("t6_pen_drop", {31'b0, pen_a}, 32'd0);
        check("t6_busy_drop", {31'b0, busy_a}, 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("t6_quiet_a", {31'b0, psel_a}, 32'd0);
            check("t6_quiet_b", {31'b0, psel_b}, 32'd0);
        end
        pready_a = 1'b1;
        ev_a = 4'b1000;
        step();
        ev_a = 4'b0000;
        step();
        check("t6_new_paddr", paddr_a, 32'hE003_0000);
        check("t6_new_pwdata", pwdata_a, 32'd1);
        step(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/events_to_apb_mc.md
# events_to_apb_mc

Parametrised multi-channel event-to-APB write bridge. Counts single-cycle event pulses on NUM_EVENTS channels in saturating per-channel counters. Each pending channel's accumulated count goes out as one APB write to a per-channel address, so bursts of events collapse into one transfer. It sits between event-generating logic and the APB fabric, as the generalised successor to the fixed three-channel event bridge.

## Interface
- NUM_EVENTS, 4, number of event channels (1..16)
- CNT_W, 16, per-channel counter width (1..31)
- ADDR_BASE, 32'hE000_0000, APB address of channel 0
- ADDR_STRIDE, 32'h0001_0000, address increment per channel index
- ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round robin
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- event_i  in  NUM_EVENTS  one-cycle event pulses, one bit per channel, sampled every edge
- apb_psel_o  out  1  APB select
- apb_penable_o  out  1  APB enable
- apb_paddr_o  out  32  ADDR_BASE + idx*ADDR_STRIDE (32-bit wrap)
- apb_pwrite_o  out  1  constant 1
- apb_pwdata_o  out  32  bit 31 = overflow flag, bits CNT_W-1:0 = reported count, others 0
- apb_pready_i  in  1  APB ready
- apb_pslverr_i  in  1  APB error, valid only when pready is high in ACCESS
- overflow_o  out  NUM_EVENTS  sticky per-channel overflow flags
- busy_o  out  1  high in SETUP or ACCESS

## Operation
- Counters: cnt[i] += event_i[i] each edge, saturating at 2^CNT_W-1. An event arriving while cnt[i] is saturated sets ovf[i]. Counters and flags are registers.
- FSM states IDLE, SETUP, ACCESS. All APB outputs are registered.
- IDLE, no counter nonzero: stay in IDLE.
- IDLE, any counter nonzero: arbiter grants channel g. At the same edge:
  - snap <= cnt[g], snap_ovf <= ovf[g]
  - cnt[g] <= event_i[g] (an event arriving that cycle is kept), ovf[g] <= 0
  - paddr <= ADDR_BASE + g*ADDR_STRIDE, pwdata <= {snap_ovf, zero pad, snap}
  - go to SETUP
- SETUP: psel=1, penable=0 for exactly one cycle, then ACCESS.
- ACCESS: psel=1, penable=1. paddr and pwdata stay stable until pready=1.
- ACCESS, pready=1 and pslverr=0: go to IDLE. Transfer done.
- ACCESS, pready=1 and pslverr=1: cnt[g] <= sat(cnt[g] + snap + event_i[g]). ovf[g] <= ovf[g] | snap_ovf | (sum saturated). Go to IDLE. The channel is re-arbitrated later, so no events are lost.
- Fixed priority: grant the lowest-index nonzero channel.
- Round robin: search starts at ptr. ptr <= g+1 (mod NUM_EVENTS) when a transfer completes, with or without error.
- In IDLE, psel=0, penable=0, and paddr and pwdata hold 0.
- overflow_o = ovf. busy_o = (state != IDLE).

## Timing
- Reset low, asynchronous:
  - state=IDLE, all counters, ovf, snap and ptr = 0
  - psel=penable=0, paddr=pwdata=0, busy=0
  - apb_pwrite_o=1
- Reset takes effect immediately, including mid-transfer. The transfer is abandoned and counts are lost.
- Latency from event pulse sampled at edge N, with the FSM idle and this the only pending channel:
  - count nonzero after N
  - grant at N+1, psel high after N+1
  - penable high after N+2
- Minimum transfer length is 3 cycles: IDLE, SETUP, ACCESS with pready=1. Every transfer is followed by at least one IDLE cycle with psel=0.
- An event on the channel being transferred, in any state, goes to cnt[g] and is reported in a later transfer.
- Simultaneous events on several channels each increment their own counter. Service order follows ARB_MODE.

## Test plan
- Single pulse on ch2 with pready tied 1 -> one write, paddr=E002_0000, pwdata=1, psel high for 2 cycles, penable for 1 cycle.
- 5 pulses on ch0 during a pready=0 stall of a ch1 transfer -> next write goes to ch0 with pwdata=5. The ch1 address and data stay stable throughout the stall.
- ARB_MODE=1, all 4 channels pending continuously -> grants rotate 0,1,2,3,0. ARB_MODE=0, same stimulus -> ch0 starves the others while it is always pending.
- CNT_W=4, 20 pulses on ch3 before any grant -> pwdata=0x8000_000F, overflow_o[3]=1 until the grant edge, then 0.
- Transfer of count 3 ends with pslverr=1 while 1 event arrives that cycle -> cnt=4. The retry writes pwdata=4.
- Reset pulse low during ACCESS -> psel and penable drop in the same cycle, counters read 0, and no transfer after release until a new event arrives.
